// File: rtl/tpu_pkg.sv
// Shared types for the TPU host interface: command opcodes, FSM states and the ACK byte.
package tpu_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_START = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ADDR     = 4'd1,
    S_WDATA    = 4'd2,
    S_WCHK     = 4'd3,
    S_RREQ     = 4'd4,
    S_RWAIT    = 4'd5,
    S_ROUT     = 4'd6,
    S_STRT     = 4'd7,
    S_WAITDONE = 4'd8,
    S_ACK      = 4'd9
  } state_e;

  localparam logic [7:0] ACK_BYTE = 8'hA5;

endpackage

// File: rtl/tpu_addr_ctr.sv
// Loadable wrapping buffer address counter paired with a 6-bit remaining-byte down-counter.
module tpu_addr_ctr
  import tpu_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_addr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              load_cnt_i,
  input  logic [5:0]        cnt_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [5:0]        cnt_q;

  // cnt_q holds (bytes remaining - 1), so the final byte is seen at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (load_addr_i) addr_q <= addr_i;
      else if (step_i) addr_q <= addr_q + 1'b1;
      if (load_cnt_i)  cnt_q <= cnt_i;
      else if (step_i) cnt_q <= cnt_q - 6'd1;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == 6'd0);

endmodule

// File: rtl/tpu_host_if.sv
// Byte-stream host command interface for the TPU unified buffer and core start/done handshake.
// Optional write checksum byte enabled by defining TPU_HOST_CKSUM_EN.
module tpu_host_if
  import tpu_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata,
  output logic              start,
  input  logic              core_done,
  output logic              busy,
  output logic              err
);

  state_e            state_q;
  logic              armed_q;
  logic              is_write_q;
  logic              drain_q;
  logic              we_q;
  logic              re_q;
  logic              start_q;
  logic              out_valid_q;
  logic [7:0]        out_data_q;
  logic [7:0]        wdata_q;
  logic [ADDR_W-1:0] waddr_q;
`ifdef TPU_HOST_CKSUM_EN
  logic [7:0]        cksum_q;
  logic              err_q;
`endif

  logic              in_acc;
  logic              out_acc;
  logic              ctr_load_addr;
  logic              ctr_load_cnt;
  logic              ctr_step;
  logic [ADDR_W-1:0] cur_addr;
  logic              ctr_last;
  op_e               op;

  assign op      = op_e'(in_data[7:6]);
  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid_q && out_ready;

  // armed_q keeps in_ready low while reset is held, even though the state reads IDLE
  assign in_ready = armed_q && ((state_q == S_IDLE) || (state_q == S_ADDR) ||
                                (state_q == S_WCHK) || ((state_q == S_WDATA) && !drain_q));

  assign ctr_load_cnt  = (state_q == S_IDLE) && in_acc && ((op == OP_WRITE) || (op == OP_READ));
  assign ctr_load_addr = (state_q == S_ADDR) && in_acc;
  assign ctr_step      = ((state_q == S_WDATA) && !drain_q && in_acc) ||
                         ((state_q == S_ROUT) && out_acc);

  tpu_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_addr_i (ctr_load_addr),
    .addr_i      (in_data[ADDR_W-1:0]),
    .load_cnt_i  (ctr_load_cnt),
    .cnt_i       (in_data[5:0]),
    .step_i      (ctr_step),
    .addr_o      (cur_addr),
    .last_o      (ctr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      armed_q     <= 1'b0;
      is_write_q  <= 1'b0;
      drain_q     <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wdata_q     <= '0;
      waddr_q     <= '0;
`ifdef TPU_HOST_CKSUM_EN
      cksum_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      armed_q <= 1'b1;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: if (in_acc) begin
          case (op)
            OP_NOP: begin
`ifdef TPU_HOST_CKSUM_EN
              err_q <= 1'b0;
`endif
            end
            OP_WRITE: begin
              is_write_q <= 1'b1;
              state_q    <= S_ADDR;
`ifdef TPU_HOST_CKSUM_EN
              cksum_q    <= '0;
`endif
            end
            OP_READ: begin
              is_write_q <= 1'b0;
              state_q    <= S_ADDR;
            end
            default: begin
              start_q <= 1'b1;
              state_q <= S_STRT;
            end
          endcase
        end
        S_ADDR: if (in_acc) begin
          if (is_write_q) begin
            state_q <= S_WDATA;
          end else begin
            re_q    <= 1'b1;
            state_q <= S_RREQ;
          end
        end
        // The last write strobe is issued from a drain cycle so it never overlaps IDLE
        S_WDATA: if (drain_q) begin
          drain_q <= 1'b0;
`ifdef TPU_HOST_CKSUM_EN
          state_q <= S_WCHK;
`else
          state_q <= S_IDLE;
`endif
        end else if (in_acc) begin
          wdata_q <= in_data;
          waddr_q <= cur_addr;
          we_q    <= 1'b1;
          drain_q <= ctr_last;
`ifdef TPU_HOST_CKSUM_EN
          cksum_q <= cksum_q ^ in_data;
`endif
        end
        S_WCHK: begin
`ifdef TPU_HOST_CKSUM_EN
          if (in_acc) begin
            if (in_data != cksum_q) err_q <= 1'b1;
            state_q <= S_IDLE;
          end
`else
          state_q <= S_IDLE;
`endif
        end
        S_RREQ: state_q <= S_RWAIT;
        S_RWAIT: begin
          out_data_q  <= mem_rdata;
          out_valid_q <= 1'b1;
          state_q     <= S_ROUT;
        end
        S_ROUT: if (out_acc) begin
          out_valid_q <= 1'b0;
          if (ctr_last) begin
            state_q <= S_IDLE;
          end else begin
            re_q    <= 1'b1;
            state_q <= S_RREQ;
          end
        end
        S_STRT: state_q <= S_WAITDONE;
        S_WAITDONE: if (core_done) begin
          out_data_q  <= ACK_BYTE;
          out_valid_q <= 1'b1;
          state_q     <= S_ACK;
        end
        S_ACK: if (out_acc) begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = re_q;
  assign mem_raddr = cur_addr;
  assign start     = start_q;
  assign busy      = (state_q != S_IDLE);
`ifdef TPU_HOST_CKSUM_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_host_if.sv
// Directed self-checking bench for tpu_host_if with a behavioural 16-byte buffer model.
module tb_tpu_host_if;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       mem_re;
  logic [3:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic       start;
  logic       core_done;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int idle_viol = 0;

  logic [7:0] mem [16];
  logic [3:0] wlog_a [$];
  logic [7:0] wlog_d [$];

  always #5 clk = ~clk;

  tpu_host_if #(.ADDR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .start     (start),
    .core_done (core_done),
    .busy      (busy),
    .err       (err)
  );

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
      wlog_a.push_back(mem_waddr);
      wlog_d.push_back(mem_wdata);
    end
    if (mem_re) mem_rdata <= mem[mem_raddr];
    if (start) start_cnt <= start_cnt + 1;
  end

  always @(negedge clk)
    if (rst_n && !busy && (mem_we || mem_re || start)) idle_viol <= idle_viol + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout byte=%h in_ready=%b required 1", b, in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    ok = out_valid;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({in_ready, out_valid, mem_we, mem_re, start, busy, err} !== 7'b0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b ov=%b od=%h we=%b re=%b st=%b busy=%b err=%b required all 0",
               in_ready, out_valid, out_data, mem_we, mem_re, start, busy, err);
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got in_ready=%b busy=%b required 1/0", in_ready, busy);
    end
    $display("reset: done");
  endtask

  task automatic test_nop();
    send(8'h00);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL nop_idle got busy=%b in_ready=%b required 0/1", busy, in_ready);
    end
    $display("nop: 0x00 accepted");
  endtask

  task automatic test_write();
    int base;
    logic [3:0] exp_a [3] = '{4'd14, 4'd15, 4'd0};
    logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
    base = wlog_a.size();
    send(8'h42); send(8'h0E); send(8'h11); send(8'h22); send(8'h33);
`ifdef TPU_HOST_CKSUM_EN
    send(8'h00);
`endif
    tick(2);
    checks++;
    if (wlog_a.size() !== base + 3) begin
      errors++;
      $display("FAIL write_count got %0d required %0d", wlog_a.size() - base, 3);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wlog_a[base+i] !== exp_a[i] || wlog_d[base+i] !== exp_d[i]) begin
          errors++;
          $display("FAIL write_%0d got %h@%0d required %h@%0d", i, wlog_d[base+i], wlog_a[base+i],
                   exp_d[i], exp_a[i]);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL write_end got busy=%b err=%b required 0/0", busy, err);
    end
    $display("write: 3 bytes at 14 with wrap");
  endtask

  task automatic test_read();
    bit ok;
    send(8'h41); send(8'h03); send(8'h5A); send(8'h6B);
`ifdef TPU_HOST_CKSUM_EN
    send(8'h31);
`endif
    tick(2);
    out_ready = 1'b0;
    send(8'h81); send(8'h03);
    wait_valid(ok);
    checks++;
    if (!ok || out_data !== 8'h5A) begin
      errors++;
      $display("FAIL read_first got valid=%b data=%h required 1/5a", ok, out_data);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL read_busy got in_ready=%b busy=%b required 0/1", in_ready, busy);
    end
    tick(5);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      errors++;
      $display("FAIL read_hold got valid=%b data=%h required 1/5a", out_valid, out_data);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_consumed got valid=%b required 0", out_valid);
    end
    wait_valid(ok);
    checks++;
    if (!ok || out_data !== 8'h6B) begin
      errors++;
      $display("FAIL read_second got valid=%b data=%h required 1/6b", ok, out_data);
    end
    consume();
    tick(1);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_end got busy=%b valid=%b required 0/0", busy, out_valid);
    end
    $display("read: 2 bytes from 3 with backpressure");
  endtask

  task automatic test_start();
    bit ok;
    int base;
    base = start_cnt;
    send(8'hC0);
    checks++;
    if (start !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse got start=%b in_ready=%b required 1/0", start, in_ready);
    end
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    checks++;
    if (start !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_early_done got start=%b valid=%b busy=%b required 0/0/1", start, out_valid, busy);
    end
    tick(5);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_wait got valid=%b required 0", out_valid);
    end
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
    wait_valid(ok);
    checks++;
    if (!ok || out_data !== 8'hA5) begin
      errors++;
      $display("FAIL start_ack got valid=%b data=%h required 1/a5", ok, out_data);
    end
    checks++;
    if (start_cnt - base !== 1) begin
      errors++;
      $display("FAIL start_count got %0d required 1", start_cnt - base);
    end
    consume();
    tick(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_end got busy=%b required 0", busy);
    end
    $display("start: pulse and ack");
  endtask

  task automatic test_reset_abort();
    bit ok;
    int base;
    send(8'h41); send(8'h05); send(8'h77); send(8'h88);
`ifdef TPU_HOST_CKSUM_EN
    send(8'hFF);
`endif
    tick(2);
    base = wlog_a.size();
    send(8'h43); send(8'h02); send(8'hAA); send(8'hBB);
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL abort_pending_we got %b required 1", mem_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, mem_we, mem_re, start, busy} !== 6'b0) begin
      errors++;
      $display("FAIL abort_async got rdy=%b ov=%b we=%b re=%b st=%b busy=%b required all 0",
               in_ready, out_valid, mem_we, mem_re, start, busy);
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (wlog_a.size() !== base + 1) begin
      errors++;
      $display("FAIL abort_writes got %0d required 1", wlog_a.size() - base);
    end
    send(8'h81);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_cmd got busy=%b in_ready=%b required 1/1", busy, in_ready);
    end
    send(8'h05);
    wait_valid(ok);
    checks++;
    if (!ok || out_data !== 8'h77) begin
      errors++;
      $display("FAIL abort_read0 got valid=%b data=%h required 1/77", ok, out_data);
    end
    consume();
    wait_valid(ok);
    checks++;
    if (!ok || out_data !== 8'h88) begin
      errors++;
      $display("FAIL abort_read1 got valid=%b data=%h required 1/88", ok, out_data);
    end
    consume();
    tick(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_end got busy=%b required 0", busy);
    end
    $display("reset_abort: write aborted, read decoded");
  endtask

`ifdef TPU_HOST_CKSUM_EN
  task automatic test_cksum();
    send(8'h41); send(8'h00); send(8'h0F); send(8'hF0); send(8'hFF);
    tick(2);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL cksum_good got err=%b required 0", err);
    end
    send(8'h41); send(8'h00); send(8'h0F); send(8'hF0); send(8'h00);
    tick(1);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL cksum_bad got err=%b required 1", err);
    end
    send(8'h00);
    tick(1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL cksum_clear got err=%b required 0", err);
    end
    $display("cksum: good, bad, cleared");
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    core_done = 1'b0;
    test_reset();
    test_nop();
    test_write();
    test_read();
    test_start();
    test_reset_abort();
`ifdef TPU_HOST_CKSUM_EN
    test_cksum();
`endif
    checks++;
    if (idle_viol !== 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL idle_strobes got viol=%0d err=%b required 0/0", idle_viol, err);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
